// File: rtl/color_scan_if.sv
// Signal bundle between the colour-sensor frequency counter side and the color_scan sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface color_scan_if #(
    parameter int FREQ_W = 33
);
    logic              start;
    logic [FREQ_W-1:0] freq_in;
    logic              done_count_in;
    logic              freq_enable;
    logic              s2;
    logic              s3;
    logic [FREQ_W-1:0] red_freq;
    logic [FREQ_W-1:0] green_freq;
    logic [FREQ_W-1:0] blue_freq;
    logic [FREQ_W-1:0] clear_freq;
    logic [1:0]        color_code;
    logic              color_valid;
    logic              busy;
    logic              timeout_err;

    modport master (
        output start, freq_in, done_count_in,
        input  freq_enable, s2, s3, red_freq, green_freq, blue_freq, clear_freq,
               color_code, color_valid, busy, timeout_err
    );

    modport slave (
        input  start, freq_in, done_count_in,
        output freq_enable, s2, s3, red_freq, green_freq, blue_freq, clear_freq,
               color_code, color_valid, busy, timeout_err
    );
endinterface

// File: rtl/color_scan.sv
// Colour-sensor scan sequencer: steps the s2/s3 filter through red, green, blue, clear, gathers
// one count per channel and classifies the dominant colour. COLOR_SCAN_CONTINUOUS_EN repeats scans forever.
module color_scan #(
    parameter int FREQ_W         = 33,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 8000000,
    parameter int MIN_CLEAR      = 100,
    parameter int MARGIN_SHIFT   = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    color_scan_if.slave  bus
);

`ifdef COLOR_SCAN_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FREQ_W-1:0] CLEAR_MIN    = FREQ_W'(MIN_CLEAR);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_NEXT, S_CLASSIFY, S_DONE
    } state_t;

    state_t            r_state;
    logic [1:0]        r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_freq_enable, r_s2, r_s3, r_color_valid, r_busy, r_timeout_err;
    logic [1:0]        r_color_code;
    logic [FREQ_W-1:0] r_red, r_green, r_blue, r_clear;
    logic [FREQ_W-1:0] w_meas;
    logic [1:0]        w_class;

    function automatic logic [1:0] filter_code(input logic [1:0] ch);
        case (ch)
            2'd0:    return 2'b00;
            2'd1:    return 2'b11;
            2'd2:    return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Widened by one bit so x + x>>MARGIN_SHIFT can never wrap.
    function automatic logic beats(input logic [FREQ_W-1:0] w, input logic [FREQ_W-1:0] x);
        logic [FREQ_W:0] lim;
        lim = {1'b0, x} + {1'b0, x >> MARGIN_SHIFT};
        return {1'b0, w} > lim;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_class = 2'd0;
        if (r_clear >= CLEAR_MIN) begin
            if (beats(r_red, r_green) && beats(r_red, r_blue))
                w_class = 2'd1;
            else if (beats(r_green, r_red) && beats(r_green, r_blue))
                w_class = 2'd2;
            else if (beats(r_blue, r_red) && beats(r_blue, r_green))
                w_class = 2'd3;
        end
    end

    assign w_meas = bus.done_count_in ? bus.freq_in : '0;

    // NOTE: sequential state uses non-blocking assignments only; the channel registers are
    // ordinary flops (not a memory) and are cleared by reset like everything else.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_ch          <= '0;
            r_cnt         <= '0;
            r_freq_enable <= 1'b0;
            r_s2          <= 1'b0;
            r_s3          <= 1'b0;
            r_color_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_color_code  <= '0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_clear       <= '0;
        end else begin
            r_color_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start || CONTINUOUS) begin
                        r_state       <= S_SETTLE;
                        r_ch          <= 2'd0;
                        {r_s2, r_s3}  <= filter_code(2'd0);
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state       <= S_MEASURE;
                        r_cnt         <= '0;
                        r_freq_enable <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    // A done pulse on the final timeout cycle still counts as a real measurement.
                    if (bus.done_count_in || r_cnt == TIMEOUT_LAST) begin
                        case (r_ch)
                            2'd0:    r_red   <= w_meas;
                            2'd1:    r_green <= w_meas;
                            2'd2:    r_blue  <= w_meas;
                            default: r_clear <= w_meas;
                        endcase
                        if (!bus.done_count_in)
                            r_timeout_err <= 1'b1;
                        r_freq_enable <= 1'b0;
                        r_state       <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_ch != 2'd3) begin
                        r_ch         <= r_ch + 1'b1;
                        {r_s2, r_s3} <= filter_code(r_ch + 1'b1);
                        r_cnt        <= '0;
                        r_state      <= S_SETTLE;
                    end else begin
                        r_state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    r_color_code  <= w_class;
                    r_color_valid <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    if (CONTINUOUS) begin
                        r_state       <= S_SETTLE;
                        r_ch          <= 2'd0;
                        {r_s2, r_s3}  <= filter_code(2'd0);
                        r_timeout_err <= 1'b0;
                        r_cnt         <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.freq_enable = r_freq_enable;
    assign bus.s2          = r_s2;
    assign bus.s3          = r_s3;
    assign bus.red_freq    = r_red;
    assign bus.green_freq  = r_green;
    assign bus.blue_freq   = r_blue;
    assign bus.clear_freq  = r_clear;
    assign bus.color_code  = r_color_code;
    assign bus.color_valid = r_color_valid;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_color_scan.sv
// Scoreboard bench for color_scan: a counter stub answers each channel after 50 enabled cycles,
// expected scan results are queued at start and compared by a monitor on every color_valid.
module tb_color_scan;
    localparam int FREQ_W = 33;
    localparam int WINDOW = 50;
    localparam int SETTLE = 4;

    typedef struct {
        logic [1:0]        code;
        logic [FREQ_W-1:0] r, g, b, c;
        logic              tmo;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    color_scan_if #(.FREQ_W(FREQ_W)) bus ();

    color_scan #(
        .FREQ_W(FREQ_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(100),
        .MIN_CLEAR(100), .MARGIN_SHIFT(3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    int   valid_cnt = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frequency-counter stub: answers per filter code after WINDOW enabled cycles.
    logic [FREQ_W-1:0] v_r, v_g, v_b, v_c;
    bit                skip_green;
    int                stub_cnt = 0;

    always @(negedge clock) begin
        if (!bus.freq_enable) begin
            stub_cnt          = 0;
            bus.done_count_in = 1'b0;
        end else begin
            stub_cnt++;
            bus.done_count_in = 1'b0;
            if (stub_cnt == WINDOW) begin
                case ({bus.s2, bus.s3})
                    2'b00: begin bus.freq_in = v_r; bus.done_count_in = 1'b1; end
                    2'b11: begin bus.freq_in = v_g; bus.done_count_in = !skip_green; end
                    2'b01: begin bus.freq_in = v_b; bus.done_count_in = 1'b1; end
                    default: begin bus.freq_in = v_c; bus.done_count_in = 1'b1; end
                endcase
            end
        end
    end

    // Monitor: filter sequence, settle gaps, and scoreboard compare on color_valid.
    logic [1:0] seq [4];
    int         seq_n   = 0;
    int         low_run = 0;
    logic       prev_fe = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            seq_n   = 0;
            low_run = 0;
            prev_fe = 1'b0;
        end else begin
            if (bus.freq_enable && !prev_fe) begin
                if (seq_n < 4) seq[seq_n] = {bus.s2, bus.s3};
                seq_n++;
                check("settle_gap_ge4", 64'(low_run >= SETTLE), 64'd1);
                check("busy_while_measuring", 64'(bus.busy), 64'd1);
            end
            low_run = bus.freq_enable ? 0 : low_run + 1;
            prev_fe = bus.freq_enable;
            if (bus.color_valid) begin
                exp_t e;
                valid_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_color_valid", 64'd0, 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("color_code",  64'(bus.color_code),  64'(e.code));
                    check("red_freq",    64'(bus.red_freq),    64'(e.r));
                    check("green_freq",  64'(bus.green_freq),  64'(e.g));
                    check("blue_freq",   64'(bus.blue_freq),   64'(e.b));
                    check("clear_freq",  64'(bus.clear_freq),  64'(e.c));
                    check("timeout_err", 64'(bus.timeout_err), 64'(e.tmo));
                    check("busy_at_valid", 64'(bus.busy), 64'd1);
                    check("channel_count", 64'(seq_n), 64'd4);
                    check("filter_ch0", 64'(seq[0]), 64'(2'b00));
                    check("filter_ch1", 64'(seq[1]), 64'(2'b11));
                    check("filter_ch2", 64'(seq[2]), 64'(2'b01));
                    check("filter_ch3", 64'(seq[3]), 64'(2'b10));
                end
                seq_n = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock) bus.start = 1'b1;
        @(negedge clock) bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000 && bus.busy; i++) @(negedge clock);
        if (bus.busy) check(name, 64'd0, 64'd1);
    endtask

    task automatic set_stub(input logic [FREQ_W-1:0] r, g, b, c, input bit skip_g);
        v_r = r; v_g = g; v_b = b; v_c = c; skip_green = skip_g;
    endtask

    task automatic run_scan(input logic [FREQ_W-1:0] r, g, b, c, input bit skip_g,
                            input logic [1:0] code, input logic tmo);
        exp_t e;
        set_stub(r, g, b, c, skip_g);
        e.code = code; e.r = r; e.g = skip_g ? '0 : g; e.b = b; e.c = c; e.tmo = tmo;
        sb.push_back(e);
        pulse_start();
        wait_idle("scan_completion_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_freq_enable"}, 64'(bus.freq_enable), 64'd0);
        check({tag, "_s2s3"},        64'({bus.s2, bus.s3}), 64'd0);
        check({tag, "_busy"},        64'(bus.busy), 64'd0);
        check({tag, "_valid"},       64'(bus.color_valid), 64'd0);
        check({tag, "_code"},        64'(bus.color_code), 64'd0);
        check({tag, "_timeout"},     64'(bus.timeout_err), 64'd0);
        check({tag, "_freqs_or"},    64'(bus.red_freq | bus.green_freq | bus.blue_freq | bus.clear_freq), 64'd0);
    endtask

    initial begin
        int v0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.freq_in = '0;
        bus.done_count_in = 1'b0;
        set_stub('0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        run_scan(33'd800, 33'd200, 33'd150, 33'd1200, 1'b0, 2'd1, 1'b0); // red dominant
        run_scan(33'd300, 33'd320, 33'd100, 33'd900,  1'b0, 2'd0, 1'b0); // 320 <= 337 margin fail
        run_scan(33'd500, 33'd500, 33'd100, 33'd900,  1'b0, 2'd0, 1'b0); // red/green tie
        run_scan(33'd100, 33'd100, 33'd900, 33'd50,   1'b0, 2'd0, 1'b0); // too dark
        run_scan(33'd100, 33'd100, 33'd900, 33'd150,  1'b0, 2'd3, 1'b0); // blue dominant
        run_scan(33'd800, 33'd200, 33'd150, 33'd1200, 1'b1, 2'd1, 1'b1); // green times out
        run_scan(33'd800, 33'd200, 33'd150, 33'd1200, 1'b0, 2'd1, 1'b0); // clean scan clears error

        // Reset while measuring blue: everything returns to zero one edge later.
        set_stub(33'd100, 33'd100, 33'd900, 33'd150, 1'b0);
        pulse_start();
        for (int i = 0; i < 1000 && !(bus.freq_enable && {bus.s2, bus.s3} == 2'b01); i++)
            @(negedge clock);
        check("reached_blue_measure", 64'(bus.freq_enable && {bus.s2, bus.s3} == 2'b01), 64'd1);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_all_zero("midscan_reset");
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);

        // start pulsed during a scan must not queue another scan.
        run_scan_with_extra_start();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    task automatic run_scan_with_extra_start();
        exp_t e;
        int   v0;
        set_stub(33'd100, 33'd100, 33'd900, 33'd150, 1'b0);
        e.code = 2'd3; e.r = 33'd100; e.g = 33'd100; e.b = 33'd900; e.c = 33'd150; e.tmo = 1'b0;
        sb.push_back(e);
        v0 = valid_cnt;
        pulse_start();
        repeat (20) @(negedge clock);
        pulse_start();
        wait_idle("busy_start_scan_timeout");
        repeat (300) @(negedge clock);
        check("single_valid_pulse", 64'(valid_cnt - v0), 64'd1);
        check("idle_after_ignored_start", 64'(bus.busy), 64'd0);
    endtask

endmodule
